// File: rtl/count_display_pkg.sv
// Shared constants for count_display: active-low 7-segment patterns, digit enables, scan default.
package count_display_pkg;

  localparam int unsigned CNT_W            = 4;
  localparam int unsigned SEG_W            = 7;
  localparam int unsigned AN_W             = 2;
  localparam int unsigned SCAN_W           = 8;
  localparam int unsigned SCAN_DIV_DEFAULT = 4;

  // Active-low, bit 0 = segment a ... bit 6 = segment g
  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_A     = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_B     = 7'b0000011;
  localparam logic [SEG_W-1:0] SEG_C     = 7'b1000110;
  localparam logic [SEG_W-1:0] SEG_D     = 7'b0100001;
  localparam logic [SEG_W-1:0] SEG_E     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_F     = 7'b0001110;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;

  localparam logic [AN_W-1:0] AN_OFF = 2'b11;
  localparam logic [AN_W-1:0] AN_LO  = 2'b10;
  localparam logic [AN_W-1:0] AN_HI  = 2'b01;

  typedef enum logic {
    DIG_LO = 1'b0,
    DIG_HI = 1'b1
  } digit_e;

endpackage

// File: rtl/count_display_seg7_decode.sv
// Combinational 4-bit to active-low 7-segment decoder.
// Define HEX_DISPLAY_EN to show 10-15 as A,b,C,d,E,F; otherwise they show a dash.
module seg7_decode
  import count_display_pkg::*;
(
  input  logic [CNT_W-1:0] val_i,
  output logic [SEG_W-1:0] seg_c_o
);

  always_comb begin
    seg_c_o = SEG_DASH;
    case (val_i)
      4'd0:    seg_c_o = SEG_0;
      4'd1:    seg_c_o = SEG_1;
      4'd2:    seg_c_o = SEG_2;
      4'd3:    seg_c_o = SEG_3;
      4'd4:    seg_c_o = SEG_4;
      4'd5:    seg_c_o = SEG_5;
      4'd6:    seg_c_o = SEG_6;
      4'd7:    seg_c_o = SEG_7;
      4'd8:    seg_c_o = SEG_8;
      4'd9:    seg_c_o = SEG_9;
`ifdef HEX_DISPLAY_EN
      4'd10:   seg_c_o = SEG_A;
      4'd11:   seg_c_o = SEG_B;
      4'd12:   seg_c_o = SEG_C;
      4'd13:   seg_c_o = SEG_D;
      4'd14:   seg_c_o = SEG_E;
      4'd15:   seg_c_o = SEG_F;
`else
      default: seg_c_o = SEG_DASH;
`endif
    endcase
  end

endmodule

// File: rtl/count_display.sv
// Watches an upstream 4-bit counter, counts its wraps, flags illegal steps and
// multiplexes count / wrap count onto a two-digit display. Macro: HEX_DISPLAY_EN.
module count_display
  import count_display_pkg::*;
#(
  parameter int unsigned SCAN_DIV = SCAN_DIV_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Qa,
  input  logic             Qb,
  input  logic             Qc,
  input  logic             Qd,
  output logic [SEG_W-1:0] SEG,
  output logic [AN_W-1:0]  AN,
  output logic             WRAP,
  output logic [CNT_W-1:0] HI,
  output logic             ERR
);

  logic [CNT_W-1:0]  sync_q, sync_d, cur_q, cur_d, prev_q, prev_d, hi_q, hi_d;
  logic              valid_q, valid_d, err_q, err_d, wrap_q, wrap_d;
  logic [SCAN_W-1:0] scan_q, scan_d;
  digit_e            dsel_q, dsel_d;
  logic [SEG_W-1:0]  seg_q, seg_d, dec_seg;
  logic [AN_W-1:0]   an_q, an_d;
  logic [CNT_W-1:0]  dec_val;
  logic              evt, is_wrap, is_step;

  assign dec_val = (dsel_q == DIG_HI) ? hi_q : cur_q;

  seg7_decode u_dec (
    .val_i   (dec_val),
    .seg_c_o (dec_seg)
  );

  // Step classification on the synchronised count
  always_comb begin
    evt     = valid_q && (cur_q != prev_q);
    is_wrap = evt && (prev_q == 4'hF) && (cur_q == 4'h0);
    is_step = (cur_q == CNT_W'(prev_q + 4'd1));

    sync_d  = {Qd, Qc, Qb, Qa};
    cur_d   = sync_q;
    prev_d  = cur_q;
    valid_d = 1'b1;
    wrap_d  = is_wrap;
    hi_d    = hi_q + CNT_W'(is_wrap);
    err_d   = err_q | (evt && !is_wrap && !is_step);

    scan_d  = scan_q + SCAN_W'(1);
    dsel_d  = dsel_q;
    if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_d = '0;
      dsel_d = (dsel_q == DIG_HI) ? DIG_LO : DIG_HI;
    end

    seg_d = dec_seg;
    an_d  = (dsel_q == DIG_HI) ? AN_HI : AN_LO;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q  <= '0;
      cur_q   <= '0;
      prev_q  <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      hi_q    <= '0;
      err_q   <= 1'b0;
      scan_q  <= '0;
      dsel_q  <= DIG_LO;
      seg_q   <= SEG_BLANK;
      an_q    <= AN_OFF;
    end else begin
      sync_q  <= sync_d;
      cur_q   <= cur_d;
      prev_q  <= prev_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      hi_q    <= hi_d;
      err_q   <= err_d;
      scan_q  <= scan_d;
      dsel_q  <= dsel_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign SEG  = seg_q;
  assign AN   = an_q;
  assign WRAP = wrap_q;
  assign HI   = hi_q;
  assign ERR  = err_q;

endmodule

// File: tb/tb_count_display.sv
// Self-checking bench for count_display: vector table, directed corner sequences,
// and random stimulus against a cycle-level reference model.
module tb_count_display;

  localparam int unsigned D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] q   = 4'd0;
  logic [6:0] seg;
  logic [1:0] an;
  logic       wrap;
  logic [3:0] hi;
  logic       err;

  int checks   = 0;
  int errors   = 0;
  int wrap_cnt = 0;

  always #5 clk = ~clk;

  count_display #(.SCAN_DIV(D)) dut (
    .CLK  (clk),
    .RST  (rst),
    .Qa   (q[0]),
    .Qb   (q[1]),
    .Qc   (q[2]),
    .Qd   (q[3]),
    .SEG  (seg),
    .AN   (an),
    .WRAP (wrap),
    .HI   (hi),
    .ERR  (err)
  );

  function automatic logic [6:0] ref_dec(input int v);
    logic [6:0] r;
    case (v)
      0: r = 7'b1000000;  1: r = 7'b1111001;  2: r = 7'b0100100;  3: r = 7'b0110000;
      4: r = 7'b0011001;  5: r = 7'b0010010;  6: r = 7'b0000010;  7: r = 7'b1111000;
      8: r = 7'b0000000;  9: r = 7'b0010000;
`ifdef HEX_DISPLAY_EN
      10: r = 7'b0001000; 11: r = 7'b0000011; 12: r = 7'b1000110;
      13: r = 7'b0100001; 14: r = 7'b0000110; 15: r = 7'b0001110;
`endif
      default: r = 7'b0111111;
    endcase
    return r;
  endfunction

  // Reference model: count seen two edges late, display driven from edges-since-reset
  bit         model_on = 1'b0;
  int         m_n, m_hist, m_cur, m_prev, m_hi;
  bit         m_chk, m_err, m_wrap, dig_hi;
  logic [6:0] m_seg;
  logic [1:0] m_an;

  always @(posedge clk) begin
    if (rst) begin
      m_n = 0; m_hist = 0; m_cur = 0; m_prev = 0; m_hi = 0;
      m_chk = 1'b0; m_err = 1'b0; m_wrap = 1'b0;
      m_seg = 7'b1111111; m_an = 2'b11;
      model_on = 1'b1;
    end else if (model_on) begin
      dig_hi = ((m_n / D) % 2) == 1;
      m_an   = dig_hi ? 2'b01 : 2'b10;
      m_seg  = ref_dec(dig_hi ? m_hi : m_cur);
      m_wrap = 1'b0;
      if (m_chk && m_cur != m_prev) begin
        if (m_prev == 15 && m_cur == 0) begin
          m_wrap = 1'b1;
          m_hi   = (m_hi + 1) % 16;
        end else if ((m_prev + 1) % 16 != m_cur) begin
          m_err = 1'b1;
        end
      end
      m_n++;
      m_prev = m_cur;
      m_cur  = m_hist;
      m_hist = int'(q);
      m_chk  = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      checks++;
      if (seg !== m_seg || an !== m_an || wrap !== m_wrap ||
          hi !== 4'(m_hi) || err !== m_err) begin
        errors++;
        $display("FAIL cycle_model t=%0t seg=%b/%b an=%b/%b wrap=%b/%b hi=%0d/%0d err=%b/%b (got/exp)",
                 $time, seg, m_seg, an, m_an, wrap, m_wrap, hi, m_hi, err, m_err);
      end
      if (wrap === 1'b1) wrap_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          rst;
    logic [3:0]  q;
    int          cyc;
    logic [3:0]  exp_hi;
    bit          exp_err;
  } vec_t;

  vec_t vecs[$];
  int   p2_end;

  function automatic void push(input bit r, input int v, input int c, input int h, input bit e);
    vec_t t;
    t.rst = r; t.q = 4'(v); t.cyc = c; t.exp_hi = 4'(h); t.exp_err = e;
    vecs.push_back(t);
  endfunction

  initial begin
    // Walk one full count, then 16 more wraps (17 total), then an illegal skip, then 4 more wraps
    push(1'b1, 0, 2, 0, 1'b0);
    push(1'b0, 0, 3, 0, 1'b0);
    for (int w = 1; w <= 17; w++) begin
      for (int v = 1; v < 16; v++) push(1'b0, v, 2, (w - 1) % 16, 1'b0);
      push(1'b0, 0, 4, w % 16, 1'b0);
    end
    p2_end = vecs.size() - 1;
    for (int v = 1; v <= 3; v++) push(1'b0, v, 2, 1, 1'b0);
    push(1'b0, 5, 4, 1, 1'b1);
    push(1'b0, 6, 2, 1, 1'b1);
    push(1'b0, 7, 2, 1, 1'b1);
    for (int v = 8; v < 16; v++) push(1'b0, v, 2, 1, 1'b1);
    push(1'b0, 0, 4, 2, 1'b1);
    for (int w = 3; w <= 5; w++) begin
      for (int v = 1; v < 16; v++) push(1'b0, v, 2, w - 1, 1'b1);
      push(1'b0, 0, 4, w, 1'b1);
    end

    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      q   = vecs[i].q;
      tick(vecs[i].cyc);
      chk($sformatf("vec%0d_hi", i), 32'(hi), 32'(vecs[i].exp_hi));
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
      if (i == p2_end) chk("wrap_pulses_17", 32'(wrap_cnt), 32'd17);
    end

    // Reset mid-scan with ERR set and HI=5
    tick(1 + int'($urandom_range(0, 2)));
    chk("pre_rst_hi", 32'(hi), 32'd5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rst_seg", 32'(seg), 32'h7f);
    chk("rst_an", 32'(an), 32'h3);
    chk("rst_hi", 32'(hi), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);
    tick(1);
    chk("rst_restart_lo_an", 32'(an), 32'h2);
    chk("rst_restart_lo_seg", 32'(seg), 32'h40);
    q = 4'd1;
    tick(4);
    chk("post_rst_step_err", 32'(err), 32'd0);

    // Held count 7: digit enables alternate every D cycles, low digit shows 7
    for (int v = 2; v <= 7; v++) begin
      q = 4'(v);
      tick(1);
    end
    tick(4);
    begin
      logic [1:0] last_an;
      int         toggles;
      last_an = an;
      toggles = 0;
      for (int k = 0; k < 16; k++) begin
        tick(1);
        if (an != last_an) toggles++;
        last_an = an;
        if (an == 2'b10) chk("hold7_seg", 32'(seg), 32'h78);
      end
      chk("hold7_an_toggles", 32'(toggles), 32'd4);
    end
    chk("hold7_err", 32'(err), 32'd0);

    // HI=12 on the high digit
    rst = 1'b1; q = 4'd0;
    tick(2);
    rst = 1'b0;
    tick(2);
    for (int w = 0; w < 12; w++) begin
      for (int v = 1; v <= 16; v++) begin
        q = 4'(v % 16);
        tick(2);
      end
    end
    tick(4);
    chk("hi12_value", 32'(hi), 32'd12);
    for (int k = 0; k < 8; k++) begin
      tick(1);
`ifdef HEX_DISPLAY_EN
      if (an == 2'b01) chk("hi12_seg", 32'(seg), 32'h46);
`else
      if (an == 2'b01) chk("hi12_seg", 32'(seg), 32'h3f);
`endif
    end

    // Random steps, holds, jumps and occasional resets
    for (int k = 0; k < 3000; k++) begin
      int r;
      r = int'($urandom_range(0, 99));
      rst = 1'b0;
      if (r < 3)       rst = 1'b1;
      else if (r < 65) q = q + 4'd1;
      else if (r < 90) q = q;
      else             q = 4'($urandom_range(0, 15));
      tick(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_display.md
COUNT_DISPLAY -- requirements
Module: count_display

Interface
REQ-001 Parameter SCAN_DIV, default 4, CLK cycles per display digit slot; legal range 2..255.
REQ-002 CLK  input  1  rising-edge clock, the same clock that drives the upstream 4-bit counter.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 Qa  input  1  upstream count bit 0 (LSB).
REQ-005 Qb  input  1  upstream count bit 1.
REQ-006 Qc  input  1  upstream count bit 2.
REQ-007 Qd  input  1  upstream count bit 3 (MSB).
REQ-008 SEG  output  7  active-low segments; SEG[0]=a through SEG[6]=g.
REQ-009 AN  output  2  active-low digit enables; AN[0]=low digit, AN[1]=high digit.
REQ-010 WRAP  output  1  one-cycle pulse on each detected wrap of the count.
REQ-011 HI  output  4  wrap counter, shown on the high digit.
REQ-012 ERR  output  1  sticky flag for an illegal count step.

Function
REQ-013 The block SHALL capture {Qd,Qc,Qb,Qa} into a two-flop register chain (cur); cur lags the inputs by 2 cycles.
REQ-014 The block SHALL hold prev = cur from the previous cycle; an event occurs when cur != prev.
REQ-015 The block SHALL treat an event with cur == prev+1 (mod 16, excluding 15->0) as a legal step.
REQ-016 The block SHALL treat an event with prev == 15 and cur == 0 as a wrap: WRAP=1 for exactly the following cycle; HI increments mod 16 (15 -> 0, no saturation).
REQ-017 The block SHALL set ERR on any other event (skip, backward step) and hold it until RST; HI and WRAP are unaffected.
REQ-018 The block SHALL make no decision while cur == prev; a held count never sets ERR.
REQ-019 The block SHALL suppress the event check on the first cycle after reset (prev not yet valid).
REQ-020 The scan counter SHALL count 0..SCAN_DIV-1 and toggle the digit select at terminal count; the digit select starts at 0 (low digit).
REQ-021 When the digit select is 0, the block SHALL drive AN=2'b10 and SEG=decode(cur); when it is 1, AN=2'b01 and SEG=decode(HI).
REQ-022 SEG and AN SHALL be registered, so the display lags the digit select by 1 cycle.
REQ-023 Decode of 0-9 SHALL follow standard 7-segment patterns, active-low (0 -> 7'b1000000).

Reset
REQ-024 With RST=1 at a rising edge, the block SHALL clear cur, prev, HI, ERR, WRAP, the scan counter and the digit select to 0, and set AN=2'b11 and SEG=7'b1111111 (blank).
REQ-025 RST SHALL take priority over every event, including a wrap in the same cycle.
REQ-026 Reset asserted mid-scan SHALL restart the display at the low digit.

Configuration
REQ-027 With HEX_DISPLAY_EN defined, digit values 10-15 SHALL decode to A,b,C,d,E,F.
REQ-028 Without HEX_DISPLAY_EN, digit values 10-15 SHALL decode to a single dash (7'b0111111), and no other behaviour SHALL change.

Structure
REQ-029 Package count_display_pkg SHALL hold the 16 segment-pattern constants, the blank and dash constants, and the default SCAN_DIV.
REQ-030 Sub-module seg7_decode SHALL be a purely combinational 4-bit to 7-bit decoder, instantiated once; HEX_DISPLAY_EN applies inside it.

Verification
REQ-031 Reset then drive count 0..15..0 with one step per 20 ns -> WRAP pulses once 2 cycles after 0 appears; HI=1; ERR=0.
REQ-032 Drive 3 then 5 -> ERR=1 and stays 1 through further legal steps; HI unchanged.
REQ-033 Drive 17 full wraps -> HI returns to 1 (mod 16); 17 WRAP pulses, each exactly 1 cycle wide.
REQ-034 Hold count=7 with SCAN_DIV=4 -> AN alternates 10/01 every 4 cycles; SEG=7'b1111000 whenever AN=2'b10.
REQ-035 HI=12: with HEX_DISPLAY_EN, SEG=C pattern when AN=2'b01; without it, SEG=7'b0111111.
REQ-036 Assert RST for 1 cycle with ERR=1, HI=5 and the scan mid-count -> next cycle all outputs match the reset values; a following step 0->1 sets no ERR.
